int_ctrl: RTL and testbench
===========================

# int_ctrl

Parametrised, memory-mapped interrupt controller between the peripherals (UART, LED, timers) and the 8-bit CPU. It replaces the single hard-wired interrupt request and vector register with NUM_SRC prioritised sources, each with its own enable bit, pending bit, edge/level mode and vector entry. It drives a request/acknowledge/return handshake toward the CPU. It is accessed over the CPU data-memory port (rs_data address, rd_data write data, mem_w_en), and its read data is muxed ahead of data memory.

## Interface
- NUM_SRC, 4: number of interrupt sources, 1..8.
- BASE_ADDR, 8'd236: first register address. The block occupies BASE_ADDR .. BASE_ADDR+3+NUM_SRC.
- EDGE_MASK, {NUM_SRC{1'b1}}: per-source mode. 1 means rising-edge triggered; 0 means level triggered.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  8  CPU data address (rs_data).
- w_data  in  8  CPU write data (rd_data).
- w_en  in  1  CPU write strobe (mem_w_en).
- hit  out  1  combinational; high when addr lies inside this block's window.
- r_data  out  8  combinational read data for addr; 0 when hit=0.
- src_req  in  NUM_SRC  raw source requests, synchronous to clock.
- int_req  out  1  interrupt request to the CPU.
- int_vec  out  8  handler address for the request currently presented.
- int_ack  in  1  one-cycle pulse: the CPU has taken the request.
- int_ret  in  1  one-cycle pulse: the CPU has executed its return-from-interrupt.

## Operation
Register map (offset from BASE_ADDR):
- +0 ENABLE: RW; bit i enables source i. Bits at or above NUM_SRC read 0 and ignore writes.
- +1 PENDING: read returns the pending bits. A write clears every bit written as 1 (write-1-to-clear).
- +2 CUR_VEC: RO; returns the latched int_vec.
- +3 CTRL: bit0 GIE is RW. bit1 IN_SERVICE is RO. bits[6:4] CUR_SRC is RO and holds the latched source index.
- +4+i VEC[i]: RW; 8-bit handler address for source i.

Pending logic:
- Edge source: pending[i] sets on a cycle where src_req[i]=1 and the previous sample of src_req[i] was 0.
- Level source: pending[i] sets on every cycle src_req[i]=1.
- Set and clear (W1C write or ack-clear) in the same cycle: set wins.

Arbitration: eligible = pending & ENABLE. The lowest eligible index wins (fixed priority).

FSM:
- IDLE: if GIE=1 and eligible≠0, latch the winning index into CUR_SRC and VEC[winner] into int_vec, then go to REQ.
- REQ: int_req=1.
  - On int_ack: clear pending[CUR_SRC], go to SERVICE.
  - If pending[CUR_SRC] or its enable drops, or GIE drops, before int_ack: withdraw and go to IDLE. int_vec keeps its value.
- SERVICE: int_req=0 and IN_SERVICE=1. No nesting: new requests only accumulate in pending. On int_ret, go to IDLE.
- int_ack outside REQ and int_ret outside SERVICE are ignored.
- A VEC write during REQ does not change the latched int_vec.

Reset values: int_req 0, int_vec 0, ENABLE 0, PENDING 0, GIE 0, all VEC 0, CUR_SRC 0, FSM IDLE, previous-sample register 0. Reset asserted mid-operation (REQ or SERVICE) returns to IDLE on the next edge and drops int_req.

## Timing
- A register write takes effect at the clock edge where w_en=1 and hit=1. Reads are combinational from addr.
- Source path:
  - Edge on src_req sampled at edge t: pending visible after t.
  - IDLE→REQ at edge t+1: int_req high after t+1.
  - Latency from src_req rising to int_req is 2 cycles.
- int_ack sampled at edge t: int_req low and IN_SERVICE high after t.
- int_ret sampled at edge t: IDLE after t. A further eligible source raises int_req after t+1.
- int_req is registered and glitch-free. int_vec is stable for the whole time int_req is high.

## Test plan
- Reset: after reset, all registers read 0, int_req=0 and int_vec=0. A src_req pulse with ENABLE=0 sets PENDING bit 0 but int_req stays 0.
- Single edge source: set VEC[0]=8'h40, ENABLE=1, GIE=1, pulse src_req[0] → int_req high 2 cycles later with int_vec=8'h40. int_ack → int_req low and PENDING bit0 cleared. int_ret → IDLE.
- Priority: src_req[2] and src_req[1] rise in the same cycle → int_vec=VEC[1]. After ack and ret, int_vec=VEC[2] and int_req rises 1 cycle after int_ret.
- Level source (EDGE_MASK bit 3=0): hold src_req[3] high; W1C write to PENDING bit3 → the bit re-sets next cycle. Drop src_req[3], then clear → stays 0.
- Withdraw: in REQ, write ENABLE=0 before any ack → int_req falls next cycle and the FSM is IDLE. A later int_ack pulse has no effect.
- Reset during SERVICE: reset pulse → IN_SERVICE=0, int_req=0, all registers back to 0.

Source files
------------

// File: rtl/int_ctrl.sv
// Prioritised, memory-mapped interrupt controller: NUM_SRC sources feeding a req/ack/ret handshake to the CPU.
// Latency: src_req edge to int_req is 2 cycles. No backpressure; new requests accumulate in PENDING while serviced.
module int_ctrl #(
  parameter int                 NUM_SRC   = 4,
  parameter logic [7:0]         BASE_ADDR = 8'd236,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}}
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         addr,
  input  logic [7:0]         w_data,
  input  logic               w_en,
  output logic               hit,
  output logic [7:0]         r_data,
  input  logic [NUM_SRC-1:0] src_req,
  output logic               int_req,
  output logic [7:0]         int_vec,
  input  logic               int_ack,
  input  logic               int_ret
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [7:0] OFS_ENABLE  = 8'd0;
  localparam logic [7:0] OFS_PENDING = 8'd1;
  localparam logic [7:0] OFS_CUR_VEC = 8'd2;
  localparam logic [7:0] OFS_CTRL    = 8'd3;

  state_t state_q, state_d;

  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] set_vec, clr_vec, eligible;
  logic [7:0]         vec_q [NUM_SRC];
  logic               gie_q;
  logic [2:0]         cur_src_q;
  logic [7:0]         int_vec_q;
  logic               int_req_q;

  logic [8:0] addr_ext, win_lo, win_hi;
  logic [7:0] offset;
  logic       wr_hit;
  logic       in_service;

  logic       latch_en, ack_take, cur_valid, found;
  logic [2:0] winner;
  logic [7:0] winner_vec;
  logic [7:0] en_ext, pend_ext;

  // ---------------------------------------------------------------- decode
  always_comb begin
    addr_ext = {1'b0, addr};
    win_lo   = {1'b0, BASE_ADDR};
    win_hi   = win_lo + 9'(3 + NUM_SRC);
    hit      = (addr_ext >= win_lo) && (addr_ext <= win_hi);
    offset   = addr - BASE_ADDR;
    wr_hit   = w_en & hit;
  end

  assign in_service = (state_q == S_SERVICE);
  assign eligible   = pending_q & enable_q;

  // ------------------------------------------------------ fixed priority
  always_comb begin
    found      = 1'b0;
    winner     = 3'd0;
    winner_vec = 8'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && eligible[i]) begin
        found      = 1'b1;
        winner     = 3'(i);
        winner_vec = vec_q[i];
      end
    end
  end

  // The request stays valid only while its source is still pending and enabled.
  always_comb begin
    cur_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (3'(i) == cur_src_q) begin
        cur_valid = pending_q[i] & enable_q[i];
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      int_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_req_q <= (state_d == S_REQ);
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    ack_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gie_q && found) begin
          latch_en = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (!(gie_q && cur_valid)) begin
          state_d = S_IDLE;
        end else if (int_ack) begin
          ack_take = 1'b1;
          state_d  = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (int_ret) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign int_req = int_req_q;
  assign int_vec = int_vec_q;

  // -------------------------------------------------------------- pending
  always_comb begin
    set_vec = (src_req & ~src_prev_q & EDGE_MASK) | (src_req & ~EDGE_MASK);
    clr_vec = '0;
    if (wr_hit && offset == OFS_PENDING) begin
      clr_vec = w_data[NUM_SRC-1:0];
    end
    if (ack_take) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (3'(i) == cur_src_q) begin
          clr_vec[i] = 1'b1;
        end
      end
    end
    // Set is OR-ed in last so a coincident set beats any clear.
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clock) begin
    if (reset) begin
      enable_q   <= '0;
      pending_q  <= '0;
      src_prev_q <= '0;
      gie_q      <= 1'b0;
      cur_src_q  <= 3'd0;
      int_vec_q  <= 8'd0;
      for (int i = 0; i < NUM_SRC; i++) begin
        vec_q[i] <= 8'd0;
      end
    end else begin
      pending_q  <= pending_d;
      src_prev_q <= src_req;
      if (latch_en) begin
        cur_src_q <= winner;
        int_vec_q <= winner_vec;
      end
      if (wr_hit) begin
        if (offset == OFS_ENABLE) begin
          enable_q <= w_data[NUM_SRC-1:0];
        end
        if (offset == OFS_CTRL) begin
          gie_q <= w_data[0];
        end
        for (int i = 0; i < NUM_SRC; i++) begin
          if (offset == 8'(4 + i)) begin
            vec_q[i] <= w_data;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ read mux
  always_comb begin
    en_ext                 = 8'd0;
    pend_ext               = 8'd0;
    en_ext[NUM_SRC-1:0]    = enable_q;
    pend_ext[NUM_SRC-1:0]  = pending_q;
    r_data                 = 8'd0;
    if (hit) begin
      case (offset)
        OFS_ENABLE:  r_data = en_ext;
        OFS_PENDING: r_data = pend_ext;
        OFS_CUR_VEC: r_data = int_vec_q;
        OFS_CTRL:    r_data = {1'b0, cur_src_q, 2'b00, in_service, gie_q};
        default: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (offset == 8'(4 + i)) begin
              r_data = vec_q[i];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: four sources, source 3 level-triggered, window at 0xEC..0xF3.
module tb_int_ctrl;

  localparam logic [7:0] A_EN   = 8'hEC;
  localparam logic [7:0] A_PEND = 8'hED;
  localparam logic [7:0] A_CVEC = 8'hEE;
  localparam logic [7:0] A_CTRL = 8'hEF;
  localparam logic [7:0] A_VEC0 = 8'hF0;
  localparam logic [7:0] A_VEC1 = 8'hF1;
  localparam logic [7:0] A_VEC2 = 8'hF2;

  logic       clock;
  logic       reset;
  logic [7:0] addr;
  logic [7:0] w_data;
  logic       w_en;
  logic       hit;
  logic [7:0] r_data;
  logic [3:0] src_req;
  logic       int_req;
  logic [7:0] int_vec;
  logic       int_ack;
  logic       int_ret;

  int n_run;
  int n_fail;

  int_ctrl #(
    .NUM_SRC  (4),
    .BASE_ADDR(8'd236),
    .EDGE_MASK(4'b0111)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .w_data (w_data),
    .w_en   (w_en),
    .hit    (hit),
    .r_data (r_data),
    .src_req(src_req),
    .int_req(int_req),
    .int_vec(int_vec),
    .int_ack(int_ack),
    .int_ret(int_ret)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr   = a;
    w_data = d;
    w_en   = 1'b1;
    tick();
    w_en   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, r_data, exp);
  endtask

  task automatic pulse_src(input logic [3:0] s);
    src_req = s;
    tick();
    src_req = 4'b0000;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    addr    = 8'h00;
    w_data  = 8'h00;
    w_en    = 1'b0;
    src_req = 4'b0000;
    int_ack = 1'b0;
    int_ret = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state and window decode
    check("rst_int_req", {7'd0, int_req}, 8'h00);
    check("rst_int_vec", int_vec, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd_chk($sformatf("rst_reg%0d", i), 8'(236 + i), 8'h00);
    end
    addr = 8'hEB; #1; check("hit_below", {7'd0, hit}, 8'h00);
    addr = 8'hEC; #1; check("hit_first", {7'd0, hit}, 8'h01);
    addr = 8'hF3; #1; check("hit_last", {7'd0, hit}, 8'h01);
    addr = 8'hF4; #1; check("hit_above", {7'd0, hit}, 8'h00);

    // Pending sets while disabled, no request
    pulse_src(4'b0001);
    rd_chk("dis_pend", A_PEND, 8'h01);
    tick();
    tick();
    check("dis_no_req", {7'd0, int_req}, 8'h00);
    wr(A_PEND, 8'h01);
    rd_chk("w1c_clear", A_PEND, 8'h00);
    wr(A_EN, 8'hFF);
    rd_chk("en_mask", A_EN, 8'h0F);

    // Single edge source
    wr(A_EN, 8'h01);
    wr(A_VEC0, 8'h40);
    wr(A_CTRL, 8'h01);
    rd_chk("vec0_rw", A_VEC0, 8'h40);
    rd_chk("ctrl_gie", A_CTRL, 8'h01);
    pulse_src(4'b0001);
    check("lat_1cyc", {7'd0, int_req}, 8'h00);
    tick();
    check("lat_2cyc", {7'd0, int_req}, 8'h01);
    check("s0_vec", int_vec, 8'h40);
    rd_chk("s0_cur_vec", A_CVEC, 8'h40);
    pulse_ack();
    check("s0_ack_req", {7'd0, int_req}, 8'h00);
    rd_chk("s0_ack_pend", A_PEND, 8'h00);
    rd_chk("s0_in_svc", A_CTRL, 8'h03);
    pulse_ret();
    rd_chk("s0_ret_idle", A_CTRL, 8'h01);

    // Priority: sources 1 and 2 together
    wr(A_VEC1, 8'h55);
    wr(A_VEC2, 8'h66);
    wr(A_EN, 8'h07);
    pulse_src(4'b0110);
    tick();
    check("pri_req", {7'd0, int_req}, 8'h01);
    check("pri_vec1", int_vec, 8'h55);
    rd_chk("pri_ctrl1", A_CTRL, 8'h11);
    pulse_ack();
    rd_chk("pri_pend2", A_PEND, 8'h04);
    rd_chk("pri_svc", A_CTRL, 8'h13);
    pulse_ret();
    check("pri_ret_t", {7'd0, int_req}, 8'h00);
    tick();
    check("pri_ret_t1", {7'd0, int_req}, 8'h01);
    check("pri_vec2", int_vec, 8'h66);
    rd_chk("pri_ctrl2", A_CTRL, 8'h21);
    pulse_ack();
    pulse_ret();
    rd_chk("pri_pend0", A_PEND, 8'h00);

    // Level source 3 (not enabled)
    src_req = 4'b1000;
    tick();
    rd_chk("lvl_set", A_PEND, 8'h08);
    wr(A_PEND, 8'h08);
    rd_chk("lvl_reset", A_PEND, 8'h08);
    src_req = 4'b0000;
    tick();
    wr(A_PEND, 8'h08);
    rd_chk("lvl_clr", A_PEND, 8'h00);
    tick();
    rd_chk("lvl_stay", A_PEND, 8'h00);

    // Withdraw by disabling while in REQ
    wr(A_EN, 8'h01);
    pulse_src(4'b0001);
    tick();
    check("wd_req", {7'd0, int_req}, 8'h01);
    wr(A_EN, 8'h00);
    tick();
    check("wd_drop", {7'd0, int_req}, 8'h00);
    check("wd_vec_kept", int_vec, 8'h40);
    rd_chk("wd_idle", A_CTRL, 8'h01);
    pulse_ack();
    check("wd_ack_req", {7'd0, int_req}, 8'h00);
    rd_chk("wd_ack_ctrl", A_CTRL, 8'h01);
    rd_chk("wd_ack_pend", A_PEND, 8'h01);

    // Reset during SERVICE
    wr(A_EN, 8'h01);
    tick();
    check("rs_req", {7'd0, int_req}, 8'h01);
    pulse_ack();
    rd_chk("rs_svc", A_CTRL, 8'h03);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs_int_req", {7'd0, int_req}, 8'h00);
    check("rs_int_vec", int_vec, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd_chk($sformatf("rs_reg%0d", i), 8'(236 + i), 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
